// File: rtl/hazard_forward_unit_pkg.sv
// Shared constants for the EX-stage operand forwarding selects.
// Encoding matches the mux3 priority: data1 = MEM, data2 = WB, data3 = register file.
package hazard_forward_unit_pkg;

    typedef logic [1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_SEL_MEM = 2'b10;
    localparam fwd_sel_t FWD_SEL_WB  = 2'b01;
    localparam fwd_sel_t FWD_SEL_RF  = 2'b00;

    localparam int REG_ADDR_WIDTH_DEFAULT = 5;
    localparam int CNT_WIDTH_DEFAULT      = 32;

endpackage

// File: rtl/hazard_stage_slot.sv
// One in-flight instruction record {valid, rd, regwrite, memread}.
// Bubble clears the whole record so an empty slot carries no stale destination.
module hazard_stage_slot #(
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      hold_i,
    input  logic                      bubble_i,
    input  logic                      valid_i,
    input  logic [REG_ADDR_WIDTH-1:0] rd_i,
    input  logic                      regwrite_i,
    input  logic                      memread_i,
    output logic                      valid_o,
    output logic [REG_ADDR_WIDTH-1:0] rd_o,
    output logic                      regwrite_o,
    output logic                      memread_o
);

    logic                      valid_q;
    logic [REG_ADDR_WIDTH-1:0] rd_q;
    logic                      regwrite_q;
    logic                      memread_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= 1'b0;
            rd_q       <= '0;
            regwrite_q <= 1'b0;
            memread_q  <= 1'b0;
        end else if (!hold_i) begin
            if (bubble_i) begin
                valid_q    <= 1'b0;
                rd_q       <= '0;
                regwrite_q <= 1'b0;
                memread_q  <= 1'b0;
            end else begin
                valid_q    <= valid_i;
                rd_q       <= rd_i;
                regwrite_q <= regwrite_i;
                memread_q  <= memread_i;
            end
        end
    end

    assign valid_o    = valid_q;
    assign rd_o       = rd_q;
    assign regwrite_o = regwrite_q;
    assign memread_o  = memread_q;

endmodule

// File: rtl/hazard_forward_unit.sv
// Forwarding-select generation and load-use stall detection for the EX operand muxes.
// Selects are computed from the ID operands and registered as the instruction enters EX.
module hazard_forward_unit
    import hazard_forward_unit_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEFAULT,
    parameter int CNT_WIDTH      = CNT_WIDTH_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      hold_i,
    input  logic                      flush_i,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1_i,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2_i,
    input  logic                      id_rs1_used_i,
    input  logic                      id_rs2_used_i,
    input  logic [REG_ADDR_WIDTH-1:0] id_rd_i,
    input  logic                      id_regwrite_i,
    input  logic                      id_memread_i,
    output logic [1:0]                fwd_rs1_sel_o,
    output logic [1:0]                fwd_rs2_sel_o,
    output logic                      stall_o,
    output logic                      ex_bubble_o,
    output logic [CNT_WIDTH-1:0]      stall_count_o
);

    logic                      ex_valid, mem_valid, wb_valid;
    logic [REG_ADDR_WIDTH-1:0] ex_rd, mem_rd, wb_rd;
    logic                      ex_regwrite, mem_regwrite, wb_regwrite;
    logic                      ex_memread, mem_memread, wb_memread;

    hazard_stage_slot #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_ex_slot (
        .clk        (clk),
        .rst        (rst),
        .hold_i     (hold_i),
        .bubble_i   (ex_bubble_o),
        .valid_i    (1'b1),
        .rd_i       (id_rd_i),
        .regwrite_i (id_regwrite_i),
        .memread_i  (id_memread_i),
        .valid_o    (ex_valid),
        .rd_o       (ex_rd),
        .regwrite_o (ex_regwrite),
        .memread_o  (ex_memread)
    );

    hazard_stage_slot #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_mem_slot (
        .clk        (clk),
        .rst        (rst),
        .hold_i     (hold_i),
        .bubble_i   (1'b0),
        .valid_i    (ex_valid),
        .rd_i       (ex_rd),
        .regwrite_i (ex_regwrite),
        .memread_i  (ex_memread),
        .valid_o    (mem_valid),
        .rd_o       (mem_rd),
        .regwrite_o (mem_regwrite),
        .memread_o  (mem_memread)
    );

    hazard_stage_slot #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_wb_slot (
        .clk        (clk),
        .rst        (rst),
        .hold_i     (hold_i),
        .bubble_i   (1'b0),
        .valid_i    (mem_valid),
        .rd_i       (mem_rd),
        .regwrite_i (mem_regwrite),
        .memread_i  (mem_memread),
        .valid_o    (wb_valid),
        .rd_o       (wb_rd),
        .regwrite_o (wb_regwrite),
        .memread_o  (wb_memread)
    );

    logic ex_writes, mem_writes;
    logic rs1_hit_ex, rs2_hit_ex, rs1_hit_mem, rs2_hit_mem;
    logic load_use;

    // Producers writing x0 are treated as non-writers, so x0 never forwards or stalls.
    assign ex_writes  = ex_valid  & ex_regwrite  & (ex_rd  != '0);
    assign mem_writes = mem_valid & mem_regwrite & (mem_rd != '0);

    assign rs1_hit_ex  = id_rs1_used_i & ex_writes  & (id_rs1_i == ex_rd);
    assign rs2_hit_ex  = id_rs2_used_i & ex_writes  & (id_rs2_i == ex_rd);
    assign rs1_hit_mem = id_rs1_used_i & mem_writes & (id_rs1_i == mem_rd);
    assign rs2_hit_mem = id_rs2_used_i & mem_writes & (id_rs2_i == mem_rd);

    assign load_use    = ~flush_i & ex_memread & (rs1_hit_ex | rs2_hit_ex);
    assign stall_o     = load_use & ~hold_i;
    assign ex_bubble_o = (load_use | flush_i) & ~hold_i;

    fwd_sel_t rs1_sel_d, rs2_sel_d, rs1_sel_q, rs2_sel_q;

    // EX match is the youngest producer and takes priority over MEM.
    always_comb begin
        rs1_sel_d = FWD_SEL_RF;
        rs2_sel_d = FWD_SEL_RF;
        if (rs1_hit_ex)       rs1_sel_d = FWD_SEL_MEM;
        else if (rs1_hit_mem) rs1_sel_d = FWD_SEL_WB;
        if (rs2_hit_ex)       rs2_sel_d = FWD_SEL_MEM;
        else if (rs2_hit_mem) rs2_sel_d = FWD_SEL_WB;
        if (ex_bubble_o) begin
            rs1_sel_d = FWD_SEL_RF;
            rs2_sel_d = FWD_SEL_RF;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rs1_sel_q <= FWD_SEL_RF;
            rs2_sel_q <= FWD_SEL_RF;
        end else if (!hold_i) begin
            rs1_sel_q <= rs1_sel_d;
            rs2_sel_q <= rs2_sel_d;
        end
    end

    logic [CNT_WIDTH-1:0] stall_count_d, stall_count_q;

    always_comb begin
        stall_count_d = stall_count_q;
        if (stall_o && (stall_count_q != {CNT_WIDTH{1'b1}}))
            stall_count_d = stall_count_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) stall_count_q <= '0;
        else     stall_count_q <= stall_count_d;
    end

    assign fwd_rs1_sel_o = rs1_sel_q;
    assign fwd_rs2_sel_o = rs2_sel_q;
    assign stall_count_o = stall_count_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench for hazard_forward_unit: forwarding selects, load-use stalls, flush, hold,
// x0 handling, counter saturation (4-bit counter) and mid-stream reset.
module tb_hazard_forward_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       hold_i, flush_i;
    logic [4:0] id_rs1_i, id_rs2_i, id_rd_i;
    logic       id_rs1_used_i, id_rs2_used_i, id_regwrite_i, id_memread_i;
    logic [1:0] fwd_rs1_sel_o, fwd_rs2_sel_o;
    logic       stall_o, ex_bubble_o;
    logic [3:0] stall_count_o;

    int checks = 0;
    int errors = 0;

    hazard_forward_unit #(.REG_ADDR_WIDTH(5), .CNT_WIDTH(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .hold_i        (hold_i),
        .flush_i       (flush_i),
        .id_rs1_i      (id_rs1_i),
        .id_rs2_i      (id_rs2_i),
        .id_rs1_used_i (id_rs1_used_i),
        .id_rs2_used_i (id_rs2_used_i),
        .id_rd_i       (id_rd_i),
        .id_regwrite_i (id_regwrite_i),
        .id_memread_i  (id_memread_i),
        .fwd_rs1_sel_o (fwd_rs1_sel_o),
        .fwd_rs2_sel_o (fwd_rs2_sel_o),
        .stall_o       (stall_o),
        .ex_bubble_o   (ex_bubble_o),
        .stall_count_o (stall_count_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                          input logic u2, input logic [4:0] rd, input logic rw, input logic mr);
        id_rs1_i      = rs1;
        id_rs1_used_i = u1;
        id_rs2_i      = rs2;
        id_rs2_used_i = u2;
        id_rd_i       = rd;
        id_regwrite_i = rw;
        id_memread_i  = mr;
        #1;
    endtask

    task automatic drain();
        set_id(0, 0, 0, 0, 0, 0, 0);
        repeat (3) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; hold_i = 1'b0; flush_i = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0);
        repeat (2) tick();
        rst = 1'b0;
        #1;
        checks++;
        if (fwd_rs1_sel_o !== 2'b00 || fwd_rs2_sel_o !== 2'b00) begin
            errors++;
            $display("FAIL reset_sel got %b/%b exp 00/00", fwd_rs1_sel_o, fwd_rs2_sel_o);
        end
        checks++;
        if (stall_o !== 1'b0 || ex_bubble_o !== 1'b0 || stall_count_o !== 4'd0) begin
            errors++;
            $display("FAIL reset_ctl got stall=%b bub=%b cnt=%0d exp 0/0/0",
                     stall_o, ex_bubble_o, stall_count_o);
        end
    endtask

    task automatic test_ex_forward();
        drain();
        set_id(1, 1, 2, 1, 5, 1, 0);   // add x5, x1, x2
        tick();
        set_id(5, 1, 6, 1, 8, 1, 0);   // add x8, x5, x6
        checks++;
        if (stall_o !== 1'b0) begin
            errors++;
            $display("FAIL ex_fwd_nostall got %b exp 0", stall_o);
        end
        tick();
        checks++;
        if (fwd_rs1_sel_o !== 2'b10 || fwd_rs2_sel_o !== 2'b00) begin
            errors++;
            $display("FAIL ex_fwd got %b/%b exp 10/00", fwd_rs1_sel_o, fwd_rs2_sel_o);
        end
    endtask

    task automatic test_wb_forward();
        drain();
        set_id(1, 1, 2, 1, 5, 1, 0);   // add x5
        tick();
        set_id(0, 0, 0, 0, 0, 0, 0);   // nop
        tick();
        set_id(3, 1, 5, 1, 9, 1, 0);   // add x9, x3, x5
        tick();
        checks++;
        if (fwd_rs1_sel_o !== 2'b00 || fwd_rs2_sel_o !== 2'b01) begin
            errors++;
            $display("FAIL wb_fwd got %b/%b exp 00/01", fwd_rs1_sel_o, fwd_rs2_sel_o);
        end
        set_id(1, 1, 2, 1, 5, 1, 0);   // add x5
        tick();
        set_id(1, 1, 3, 1, 5, 1, 0);   // add x5 again (younger)
        tick();
        set_id(5, 1, 5, 1, 10, 1, 0);  // add x10, x5, x5
        tick();
        checks++;
        if (fwd_rs1_sel_o !== 2'b10 || fwd_rs2_sel_o !== 2'b10) begin
            errors++;
            $display("FAIL youngest_wins got %b/%b exp 10/10", fwd_rs1_sel_o, fwd_rs2_sel_o);
        end
    endtask

    task automatic test_load_use();
        drain();
        set_id(2, 1, 0, 0, 7, 1, 1);   // lw x7, 0(x2)
        tick();
        set_id(7, 1, 3, 1, 9, 1, 0);   // add x9, x7, x3
        checks++;
        if (stall_o !== 1'b1 || ex_bubble_o !== 1'b1) begin
            errors++;
            $display("FAIL load_use_stall got stall=%b bub=%b exp 1/1", stall_o, ex_bubble_o);
        end
        tick();
        checks++;
        if (stall_o !== 1'b0 || ex_bubble_o !== 1'b0 || stall_count_o !== 4'd1) begin
            errors++;
            $display("FAIL load_use_after got stall=%b bub=%b cnt=%0d exp 0/0/1",
                     stall_o, ex_bubble_o, stall_count_o);
        end
        tick();
        checks++;
        if (fwd_rs1_sel_o !== 2'b01 || fwd_rs2_sel_o !== 2'b00) begin
            errors++;
            $display("FAIL load_use_fwd got %b/%b exp 01/00", fwd_rs1_sel_o, fwd_rs2_sel_o);
        end
    endtask

    task automatic test_flush();
        drain();
        set_id(2, 1, 0, 0, 7, 1, 1);   // lw x7
        tick();
        set_id(7, 1, 0, 0, 9, 1, 0);
        flush_i = 1'b1;
        #1;
        checks++;
        if (stall_o !== 1'b0 || ex_bubble_o !== 1'b1) begin
            errors++;
            $display("FAIL flush_ctl got stall=%b bub=%b exp 0/1", stall_o, ex_bubble_o);
        end
        tick();
        flush_i = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (stall_count_o !== 4'd1 || fwd_rs1_sel_o !== 2'b00) begin
            errors++;
            $display("FAIL flush_after got cnt=%0d sel=%b exp 1/00", stall_count_o, fwd_rs1_sel_o);
        end
    endtask

    task automatic test_x0_and_unused();
        drain();
        set_id(2, 1, 0, 0, 0, 1, 1);   // lw x0
        tick();
        set_id(0, 1, 0, 1, 9, 1, 0);   // add x9, x0, x0
        checks++;
        if (stall_o !== 1'b0 || ex_bubble_o !== 1'b0) begin
            errors++;
            $display("FAIL x0_nostall got stall=%b bub=%b exp 0/0", stall_o, ex_bubble_o);
        end
        tick();
        checks++;
        if (fwd_rs1_sel_o !== 2'b00 || fwd_rs2_sel_o !== 2'b00) begin
            errors++;
            $display("FAIL x0_sel got %b/%b exp 00/00", fwd_rs1_sel_o, fwd_rs2_sel_o);
        end
        set_id(1, 1, 2, 1, 5, 1, 0);   // add x5
        tick();
        set_id(5, 0, 5, 1, 11, 1, 0);  // rs1 field x5 but unused
        tick();
        checks++;
        if (fwd_rs1_sel_o !== 2'b00 || fwd_rs2_sel_o !== 2'b10) begin
            errors++;
            $display("FAIL unused_sel got %b/%b exp 00/10", fwd_rs1_sel_o, fwd_rs2_sel_o);
        end
    endtask

    task automatic test_hold();
        drain();
        set_id(1, 1, 0, 0, 2, 1, 0);   // add x2
        tick();
        set_id(2, 1, 0, 0, 7, 1, 1);   // lw x7, 0(x2)
        tick();
        checks++;
        if (fwd_rs1_sel_o !== 2'b10) begin
            errors++;
            $display("FAIL hold_pre got %b exp 10", fwd_rs1_sel_o);
        end
        set_id(7, 1, 0, 0, 9, 1, 0);
        hold_i = 1'b1;
        #1;
        checks++;
        if (stall_o !== 1'b0 || ex_bubble_o !== 1'b0) begin
            errors++;
            $display("FAIL hold_ctl got stall=%b bub=%b exp 0/0", stall_o, ex_bubble_o);
        end
        tick();
        checks++;
        if (fwd_rs1_sel_o !== 2'b10 || stall_count_o !== 4'd1) begin
            errors++;
            $display("FAIL hold_frozen got sel=%b cnt=%0d exp 10/1", fwd_rs1_sel_o, stall_count_o);
        end
        hold_i = 1'b0;
        #1;
        checks++;
        if (stall_o !== 1'b1) begin
            errors++;
            $display("FAIL hold_release got stall=%b exp 1", stall_o);
        end
        tick();
        checks++;
        if (stall_count_o !== 4'd2) begin
            errors++;
            $display("FAIL hold_count got %0d exp 2", stall_count_o);
        end
        tick();
        checks++;
        if (fwd_rs1_sel_o !== 2'b01) begin
            errors++;
            $display("FAIL hold_fwd got %b exp 01", fwd_rs1_sel_o);
        end
    endtask

    task automatic one_stall();
        set_id(2, 1, 0, 0, 7, 1, 1);
        tick();
        set_id(7, 1, 0, 0, 9, 1, 0);
        tick();
    endtask

    task automatic test_saturation();
        drain();
        repeat (12) one_stall();
        checks++;
        if (stall_count_o !== 4'd14) begin
            errors++;
            $display("FAIL sat_mid got %0d exp 14", stall_count_o);
        end
        one_stall();
        checks++;
        if (stall_count_o !== 4'd15) begin
            errors++;
            $display("FAIL sat_top got %0d exp 15", stall_count_o);
        end
        repeat (3) one_stall();
        checks++;
        if (stall_count_o !== 4'd15) begin
            errors++;
            $display("FAIL sat_hold got %0d exp 15", stall_count_o);
        end
    endtask

    task automatic test_reset_mid();
        drain();
        set_id(1, 1, 2, 1, 5, 1, 0);   // add x5
        tick();
        set_id(5, 1, 0, 0, 0, 0, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (stall_count_o !== 4'd0 || stall_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_ctl got cnt=%0d stall=%b exp 0/0", stall_count_o, stall_o);
        end
        tick();
        checks++;
        if (fwd_rs1_sel_o !== 2'b00 || fwd_rs2_sel_o !== 2'b00) begin
            errors++;
            $display("FAIL rst_mid_sel got %b/%b exp 00/00", fwd_rs1_sel_o, fwd_rs2_sel_o);
        end
    endtask

    initial begin
        test_reset();
        test_ex_forward();
        test_wb_forward();
        test_load_use();
        test_flush();
        test_x0_and_unused();
        test_hold();
        test_saturation();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
